// File: rtl/sram_burst_ctrl_if.sv
// sram_burst_ctrl_if: byte-serial command and response streams of the SRAM burst engine
interface sram_burst_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
    modport slave  (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: byte-serial command engine with burst read/write/fill over a DEPTH x DATA_W array
module sram_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_burst_ctrl_if.slave   bus,
    output logic               busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int AB = (ADDR_W + 7) / 8;
    localparam int DB = DATA_W / 8;
    localparam logic [1:0] AB_LAST = 2'(AB - 1);
    localparam logic [1:0] DB_LAST = 2'(DB - 1);
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_FILL = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RFETCH, RSEND, FILL} state_t;

    state_t state, state_nx;
    logic [1:0] op, bcnt;
    logic [5:0] len;
    logic [ADDR_W-1:0] addr;
    logic [15:0] anext;
    logic [DATA_W-1:0] wword, wfull, rword, mem_wdata;
    logic cmd_fire, rsp_fire, last_b, mem_we, rsp_valid_q;
    logic [DATA_W-1:0] mem [DEPTH];

    assign bus.cmd_ready = rst_n && (state == IDLE || state == ADDR || state == WDATA);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data = rword[7:0];
    assign busy = state != IDLE;

    always_comb begin
        cmd_fire = bus.cmd_valid && bus.cmd_ready;
        rsp_fire = rsp_valid_q && bus.rsp_ready;
        last_b = bcnt == (state == ADDR ? AB_LAST : DB_LAST);
        anext = 16'(addr);
        wfull = wword;
        for (int i = 0; i < AB; i++)
            if (bcnt == 2'(i)) anext[i*8 +: 8] = bus.cmd_data;
        for (int i = 0; i < DB; i++)
            if (bcnt == 2'(i)) wfull[i*8 +: 8] = bus.cmd_data;
        mem_we = rst_n && (state == FILL || (state == WDATA && cmd_fire && last_b && op == OP_WRITE));
        mem_wdata = state == FILL ? wword : wfull;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_fire && bus.cmd_data[7:6] != 2'b00) state_nx = ADDR;
            ADDR:    if (cmd_fire && last_b) state_nx = op == OP_READ ? RFETCH : WDATA;
            WDATA:   if (cmd_fire && last_b) state_nx = op == OP_FILL ? FILL : (len == 6'd0 ? IDLE : WDATA);
            RFETCH:  state_nx = RSEND;
            RSEND:   if (rsp_fire && last_b) state_nx = len == 6'd0 ? IDLE : RFETCH;
            FILL:    if (len == 6'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // len holds remaining words minus one; each completed word decrements it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op <= '0;
            len <= '0;
            bcnt <= '0;
            addr <= '0;
            wword <= '0;
            rword <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_fire) begin
                    op <= bus.cmd_data[7:6];
                    len <= bus.cmd_data[5:0];
                    bcnt <= '0;
                end
                ADDR: if (cmd_fire) begin
                    addr <= anext[ADDR_W-1:0];
                    bcnt <= last_b ? 2'd0 : bcnt + 2'd1;
                end
                WDATA: if (cmd_fire) begin
                    wword <= wfull;
                    bcnt <= last_b ? 2'd0 : bcnt + 2'd1;
                    if (last_b && op == OP_WRITE) begin
                        addr <= addr + ADDR_W'(1);
                        len <= len - 6'd1;
                    end
                end
                RFETCH: begin
                    rword <= mem[addr];
                    rsp_valid_q <= 1'b1;
                    bcnt <= '0;
                end
                RSEND: if (rsp_fire) begin
                    rword <= rword >> 8;
                    bcnt <= last_b ? 2'd0 : bcnt + 2'd1;
                    if (last_b) begin
                        rsp_valid_q <= 1'b0;
                        addr <= addr + ADDR_W'(1);
                        len <= len - 6'd1;
                    end
                end
                FILL: begin
                    addr <= addr + ADDR_W'(1);
                    len <= len - 6'd1;
                end
                default: ;
            endcase
        end

    always_ff @(posedge clk)
        if (mem_we) mem[addr] <= mem_wdata;
endmodule
